// File: rtl/reg_status_exec_pkg.sv
// Shared widths, tag encodings and ALU opcode for the register status table.
package reg_status_exec_pkg;

  localparam int unsigned NREG_DEFAULT = 64;
  localparam int unsigned WORD_W       = 32;
  localparam int unsigned TAG_W        = 8;
  localparam int unsigned ADDR_W       = 6;
  localparam int unsigned SLOT_W       = 5;

  localparam int unsigned TAG_READY    = 32'h7F;
  localparam int unsigned TAG_ADD_BASE = 32'h20;
  localparam int unsigned TAG_MUL_BASE = 32'h40;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_MUL = 1'b1
  } alu_op_e;

  // Producer tag of an internal ALU slot: unit base plus slot index.
  function automatic logic [TAG_W-1:0] unit_tag(input alu_op_e op, input logic [SLOT_W-1:0] slot);
    logic [TAG_W-1:0] base;
    base = (op == ALU_MUL) ? TAG_W'(TAG_MUL_BASE) : TAG_W'(TAG_ADD_BASE);
    return base + TAG_W'(slot);
  endfunction

endpackage

// File: rtl/alu_addmul.sv
// Combinational add / signed multiply, result truncated to the word width.
module alu_addmul
  import reg_status_exec_pkg::*;
#(
  parameter int unsigned WORD = WORD_W
) (
  input  alu_op_e                 op,
  input  logic signed [WORD-1:0]  a,
  input  logic signed [WORD-1:0]  b,
  output logic        [WORD-1:0]  y
);

  // Low WORD bits of the product are the same for the full-width signed product.
  always_comb begin
    y = '0;
    if (op == ALU_MUL) y = WORD'(a * b);
    else               y = WORD'(a + b);
  end

endmodule

// File: rtl/reg_status_exec.sv
// Register status table with tag renaming, broadcast snooping and a 1-cycle add/mul unit.
module reg_status_exec
  import reg_status_exec_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEFAULT,
  parameter int unsigned WORD = WORD_W,
  parameter int unsigned TAGW = TAG_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [TAGW-1:0]         rd_tag,
  output logic [WORD-1:0]         rd_value,
  input  logic                    ren_en,
  input  logic [ADDR_W-1:0]       ren_addr,
  input  logic [TAGW-1:0]         ren_tag,
  input  logic                    set_en,
  input  logic [ADDR_W-1:0]       set_addr,
  input  logic [WORD-1:0]         set_data,
  input  logic                    cdb_valid,
  input  logic [TAGW-1:0]         cdb_tag,
  input  logic [WORD-1:0]         cdb_data,
  input  logic                    alu_valid,
  input  logic                    alu_op,
  input  logic [SLOT_W-1:0]       alu_slot,
  input  logic signed [WORD-1:0]  alu_a,
  input  logic signed [WORD-1:0]  alu_b,
  output logic                    res_valid,
  output logic [TAGW-1:0]         res_tag,
  output logic [WORD-1:0]         res_data
);

  localparam logic [TAGW-1:0] READY = TAGW'(TAG_READY);

  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [WORD-1:0] value;
  } entry_t;

  entry_t          entry_q [NREG];
  logic [WORD-1:0] alu_y_c;
  logic            res_snoop_c;
  logic            cdb_snoop_c;

  alu_addmul #(.WORD(WORD)) u_alu (
    .op (alu_op_e'(alu_op)),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y_c)
  );

  // A broadcast carrying the ready tag would otherwise overwrite every ready entry.
  always_comb begin
    res_snoop_c = res_valid && (res_tag != READY);
    cdb_snoop_c = cdb_valid && (cdb_tag != READY);
  end

  // Per-entry update: rename beats immediate write beats broadcast; internal result beats cdb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        entry_q[i] <= '{tag: READY, value: '0};
      end
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (ren_en && (ren_addr == ADDR_W'(i))) begin
          entry_q[i].tag <= ren_tag;
        end else if (set_en && (set_addr == ADDR_W'(i))) begin
          entry_q[i] <= '{tag: READY, value: set_data};
        end else if (res_snoop_c && (entry_q[i].tag == res_tag)) begin
          entry_q[i] <= '{tag: READY, value: res_data};
        end else if (cdb_snoop_c && (entry_q[i].tag == cdb_tag)) begin
          entry_q[i] <= '{tag: READY, value: cdb_data};
        end
      end
    end
  end

  // Result register; reset discards whatever was issued in the prior cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_tag   <= '0;
      res_data  <= '0;
    end else begin
      res_valid <= alu_valid;
      if (alu_valid) begin
        res_tag  <= TAGW'(unit_tag(alu_op_e'(alu_op), alu_slot));
        res_data <= alu_y_c;
      end
    end
  end

  always_comb begin
    rd_tag   = entry_q[rd_addr].tag;
    rd_value = entry_q[rd_addr].value;
  end

endmodule

// File: tb/tb_reg_status_exec.sv
// Self-checking bench: ALU vector table, directed corner sequences, randomized run vs. reference model.
module tb_reg_status_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  rd_addr;
  logic [7:0]  rd_tag;
  logic [31:0] rd_value;
  logic        ren_en;
  logic [5:0]  ren_addr;
  logic [7:0]  ren_tag;
  logic        set_en;
  logic [5:0]  set_addr;
  logic [31:0] set_data;
  logic        cdb_valid;
  logic [7:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        alu_valid;
  logic        alu_op;
  logic [4:0]  alu_slot;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        res_valid;
  logic [7:0]  res_tag;
  logic [31:0] res_data;

  always #10 clk = ~clk;

  reg_status_exec dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_tag(rd_tag), .rd_value(rd_value),
    .ren_en(ren_en), .ren_addr(ren_addr), .ren_tag(ren_tag),
    .set_en(set_en), .set_addr(set_addr), .set_data(set_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .alu_valid(alu_valid), .alu_op(alu_op), .alu_slot(alu_slot),
    .alu_a(alu_a), .alu_b(alu_b),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference state: what each register holds and what the ALU is broadcasting.
  logic [7:0]  m_tag [64];
  logic [31:0] m_val [64];
  logic        m_rv;
  logic [7:0]  m_rt;
  logic [31:0] m_rd;

  typedef struct {
    logic        op;
    logic [4:0]  slot;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  et;
    logic [31:0] ed;
  } alu_vec_t;

  alu_vec_t av [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 64; r++) begin
      m_tag[r] = 8'h7F;
      m_val[r] = 32'h0;
    end
    m_rv = 1'b0;
    m_rt = 8'h0;
    m_rd = 32'h0;
  endtask

  task automatic model_edge();
    logic [7:0]  nt [64];
    logic [31:0] nv [64];
    longint      p;
    for (int r = 0; r < 64; r++) begin
      nt[r] = m_tag[r];
      nv[r] = m_val[r];
      if (ren_en && ren_addr == 6'(r)) begin
        nt[r] = ren_tag;
      end else if (set_en && set_addr == 6'(r)) begin
        nt[r] = 8'h7F; nv[r] = set_data;
      end else if (m_rv && m_rt != 8'h7F && m_tag[r] == m_rt) begin
        nt[r] = 8'h7F; nv[r] = m_rd;
      end else if (cdb_valid && cdb_tag != 8'h7F && m_tag[r] == cdb_tag) begin
        nt[r] = 8'h7F; nv[r] = cdb_data;
      end
    end
    for (int r = 0; r < 64; r++) begin
      m_tag[r] = nt[r];
      m_val[r] = nv[r];
    end
    m_rv = alu_valid;
    if (alu_valid) begin
      p    = longint'($signed(alu_a)) * longint'($signed(alu_b));
      m_rt = (alu_op ? 8'h40 : 8'h20) + 8'(alu_slot);
      m_rd = alu_op ? p[31:0] : alu_a + alu_b;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren_en = 1'b0; set_en = 1'b0; cdb_valid = 1'b0; alu_valid = 1'b0;
  endtask

  task automatic chk_reg(input string nm, input int r, input logic [7:0] et, input logic [31:0] ev);
    rd_addr = 6'(r);
    #1;
    chk({nm, "_tag"}, 32'(rd_tag), 32'(et));
    chk({nm, "_val"}, rd_value, ev);
  endtask

  task automatic chk_res(input string nm, input logic ev, input logic [7:0] et, input logic [31:0] ed);
    chk({nm, "_valid"}, 32'(res_valid), 32'(ev));
    chk({nm, "_tag"}, 32'(res_tag), 32'(et));
    chk({nm, "_data"}, res_data, ed);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    av[0] = '{1'b0, 5'd3,  32'd7,        32'hFFFF_FFF6, 8'h23, 32'hFFFF_FFFD};
    av[1] = '{1'b1, 5'd1,  32'h0001_0000, 32'h0001_0001, 8'h41, 32'h0001_0000};
    av[2] = '{1'b0, 5'd0,  32'hFFFF_FFFF, 32'd1,        8'h20, 32'h0000_0000};
    av[3] = '{1'b1, 5'd31, 32'hFFFF_FFFD, 32'd5,        8'h5F, 32'hFFFF_FFF1};
    av[4] = '{1'b0, 5'd31, 32'h7FFF_FFFF, 32'd1,        8'h3F, 32'h8000_0000};
    av[5] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h40, 32'h0000_0001};

    rst_n = 1'b0; rd_addr = '0;
    ren_addr = '0; ren_tag = '0; set_addr = '0; set_data = '0;
    cdb_tag = '0; cdb_data = '0; alu_op = 1'b0; alu_slot = '0; alu_a = '0; alu_b = '0;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reg("rst_r0", 0, 8'h7F, 0);
    chk_reg("rst_r37", 37, 8'h7F, 0);
    chk_reg("rst_r63", 63, 8'h7F, 0);
    chk_res("rst_res", 1'b0, 8'h00, 0);
    rst_n = 1'b1;
    tick();

    // ALU vector table, issued back to back
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_op = av[i].op; alu_slot = av[i].slot;
      alu_a = av[i].a; alu_b = av[i].b;
      tick();
      chk_res($sformatf("alu_vec%0d", i), 1'b1, av[i].et, av[i].ed);
    end
    idle();
    tick();
    chk("alu_idle_valid", 32'(res_valid), 0);

    // Immediate write, rename, add result resolves the waiter
    set_en = 1'b1; set_addr = 6'd5; set_data = 32'h7;
    ren_en = 1'b1; ren_addr = 6'd9; ren_tag = 8'h23;
    tick();
    idle();
    alu_valid = 1'b1; alu_op = 1'b0; alu_slot = 5'd3; alu_a = 32'd7; alu_b = 32'hFFFF_FFF6;
    tick();
    idle();
    chk_res("add_res", 1'b1, 8'h23, 32'hFFFF_FFFD);
    chk_reg("r9_pending", 9, 8'h23, 0);
    tick();
    chk_reg("r9_ready", 9, 8'h7F, 32'hFFFF_FFFD);
    chk_reg("r5_set", 5, 8'h7F, 32'h7);

    // Multiply fan-out to two waiters
    ren_en = 1'b1; ren_addr = 6'd1; ren_tag = 8'h41;
    tick();
    ren_addr = 6'd2;
    tick();
    idle();
    alu_valid = 1'b1; alu_op = 1'b1; alu_slot = 5'd1; alu_a = 32'h0001_0000; alu_b = 32'h0001_0001;
    tick();
    idle();
    chk_res("mul_res", 1'b1, 8'h41, 32'h0001_0000);
    tick();
    chk_reg("r1_fan", 1, 8'h7F, 32'h0001_0000);
    chk_reg("r2_fan", 2, 8'h7F, 32'h0001_0000);

    // External broadcast hits only its own tag
    ren_en = 1'b1; ren_addr = 6'd10; ren_tag = 8'h85;
    tick();
    ren_addr = 6'd11; ren_tag = 8'h86;
    tick();
    idle();
    cdb_valid = 1'b1; cdb_tag = 8'h85; cdb_data = 32'h1234;
    tick();
    idle();
    chk_reg("r10_cdb", 10, 8'h7F, 32'h1234);
    chk_reg("r11_other", 11, 8'h86, 0);

    // Rename colliding with a matching broadcast keeps the new tag pending
    ren_en = 1'b1; ren_addr = 6'd4; ren_tag = 8'h22;
    tick();
    cdb_valid = 1'b1; cdb_tag = 8'h22; cdb_data = 32'd5;
    tick();
    idle();
    chk_reg("r4_collide", 4, 8'h22, 0);

    // Internal result wins over cdb with the same tag
    ren_en = 1'b1; ren_addr = 6'd6; ren_tag = 8'h21;
    tick();
    idle();
    alu_valid = 1'b1; alu_op = 1'b0; alu_slot = 5'd1; alu_a = 32'd1; alu_b = 32'd2;
    tick();
    idle();
    cdb_valid = 1'b1; cdb_tag = 8'h21; cdb_data = 32'hDEAD;
    tick();
    idle();
    chk_reg("r6_prio", 6, 8'h7F, 32'd3);

    // Broadcast of the ready tag is ignored
    cdb_valid = 1'b1; cdb_tag = 8'h7F; cdb_data = 32'hBAD;
    tick();
    idle();
    chk_reg("r5_readytag", 5, 8'h7F, 32'h7);
    chk_reg("r0_readytag", 0, 8'h7F, 32'h0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      int k;
      ren_en    = ($urandom_range(0, 9) < 3);
      ren_addr  = 6'($urandom_range(0, 7));
      k         = $urandom_range(0, 2);
      ren_tag   = (k == 0) ? 8'h20 + 8'($urandom_range(0, 3)) :
                  (k == 1) ? 8'h40 + 8'($urandom_range(0, 3)) : 8'h80 + 8'($urandom_range(0, 3));
      set_en    = ($urandom_range(0, 9) < 2);
      set_addr  = 6'($urandom_range(0, 7));
      set_data  = $urandom;
      cdb_valid = ($urandom_range(0, 9) < 3);
      cdb_tag   = ($urandom_range(0, 7) == 0) ? 8'h7F :
                  ($urandom_range(0, 1) == 0) ? 8'h80 + 8'($urandom_range(0, 3)) : 8'h20 + 8'($urandom_range(0, 3));
      cdb_data  = $urandom;
      alu_valid = ($urandom_range(0, 1) == 1);
      alu_op    = 1'($urandom_range(0, 1));
      alu_slot  = 5'($urandom_range(0, 3));
      alu_a     = $urandom;
      alu_b     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      tick();
      chk("rnd_res_valid", 32'(res_valid), 32'(m_rv));
      if (m_rv) begin
        chk("rnd_res_tag", 32'(res_tag), 32'(m_rt));
        chk("rnd_res_data", res_data, m_rd);
      end
      k = $urandom_range(0, 7);
      chk_reg($sformatf("rnd_r%0d", k), k, m_tag[k], m_val[k]);
    end

    // Reset while an ALU result is outstanding and another is being issued
    idle();
    ren_en = 1'b1; ren_addr = 6'd20; ren_tag = 8'h24;
    alu_valid = 1'b1; alu_op = 1'b0; alu_slot = 5'd4; alu_a = 32'd9; alu_b = 32'd9;
    tick();
    ren_en = 1'b0;
    alu_slot = 5'd5;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_async_valid", 32'(res_valid), 0);
    @(posedge clk);
    #1;
    idle();
    model_reset();
    chk_res("midrst_res", 1'b0, 8'h00, 0);
    for (int r = 0; r < 64; r++) begin
      chk_reg($sformatf("midrst_r%0d", r), r, 8'h7F, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_valid", 32'(res_valid), 0);
    set_en = 1'b1; set_addr = 6'd3; set_data = 32'h55;
    tick();
    idle();
    chk_reg("postrst_r3", 3, 8'h7F, 32'h55);
    chk_reg("postrst_r20", 20, 8'h7F, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
